// File: rtl/t03_dpu_frame_scheduler.sv
// Frame-synchronous update scheduler: game logic hands over display state with a
// four-phase req/ack handshake, and the DPU shadow copy is refreshed only at vblank start.
module t03_dpu_frame_scheduler #(
  parameter int V_ACTIVE = 600,
  parameter int X_MAX    = 760,
  parameter int Y_MAX    = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] Hcnt,
  input  logic [10:0] Vcnt,
  input  logic        req,
  input  logic [2:0]  gameState_in,
  input  logic [1:0]  p1State_in,
  input  logic [1:0]  p2State_in,
  input  logic [3:0]  p1health_in,
  input  logic [3:0]  p2health_in,
  input  logic [10:0] x1_in,
  input  logic [10:0] x2_in,
  input  logic [10:0] y1_in,
  input  logic [10:0] y2_in,
  input  logic        p1Left_in,
  input  logic        p2Left_in,
  output logic        ack,
  output logic        busy,
  output logic [2:0]  gameState,
  output logic [1:0]  p1State,
  output logic [1:0]  p2State,
  output logic [3:0]  p1health,
  output logic [3:0]  p2health,
  output logic [10:0] x1,
  output logic [10:0] x2,
  output logic [10:0] y1,
  output logic [10:0] y2,
  output logic        p1Left,
  output logic        p2Left,
  output logic        vblank,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK} state_t;

  state_t state, state_next;
  logic   vbs;
  logic   frame_origin;
  logic   commit;

  assign vbs          = (Hcnt == 11'd0) && (Vcnt == 11'(V_ACTIVE));
  assign frame_origin = (Hcnt == 11'd0) && (Vcnt == 11'd0);
  assign commit       = (state == PENDING) && vbs;

  function automatic logic [10:0] clamp_coord(input logic [10:0] val, input logic [10:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  function automatic logic [3:0] clamp_health(input logic [3:0] val);
    return (val > 4'd9) ? 4'd9 : val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A vbs seen in IDLE is deliberately ignored; the commit waits for the next frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req)  state_next = PENDING;
      PENDING: if (vbs)  state_next = ACK;
      ACK:     if (!req) state_next = IDLE;
      default:           state_next = IDLE;
    endcase
  end

  always_comb begin
    ack  = 1'b0;
    busy = 1'b0;
    case (state)
      PENDING: busy = 1'b1;
      ACK:     ack  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gameState <= '0;
      p1State   <= '0;
      p2State   <= '0;
      p1health  <= '0;
      p2health  <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      p1Left    <= 1'b0;
      p2Left    <= 1'b0;
    end else if (commit) begin
      gameState <= gameState_in;
      p1State   <= p1State_in;
      p2State   <= p2State_in;
      p1health  <= clamp_health(p1health_in);
      p2health  <= clamp_health(p2health_in);
      x1        <= clamp_coord(x1_in, 11'(X_MAX));
      x2        <= clamp_coord(x2_in, 11'(X_MAX));
      y1        <= clamp_coord(y1_in, 11'(Y_MAX));
      y2        <= clamp_coord(y2_in, 11'(Y_MAX));
      p1Left    <= p1Left_in;
      p2Left    <= p2Left_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      vblank      <= (Vcnt >= 11'(V_ACTIVE));
      frame_start <= frame_origin;
      if (frame_origin) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: doc/t03_dpu_frame_scheduler.md
# t03_dpu_frame_scheduler

Frame-synchronous update scheduler between game logic and the display pipeline (`t03_DPUtop` inputs). Game logic requests a state update with a four-phase req/ack handshake. The block commits all display-visible state (game state, player states, health, positions, facing) into shadow registers only at the start of vertical blanking, so no frame is drawn with mixed old and new state. It also generates frame-start/vblank strobes and a free-running frame counter for blink and animation effects.

## Interface

Parameters
- `V_ACTIVE`, 600: first non-visible line; vblank starts at `Vcnt == V_ACTIVE`
- `X_MAX`, 760: largest committed x coordinate (sprite left edge)
- `Y_MAX`, 500: largest committed y coordinate (display uses `500 - y`)

Ports
- `clk`  in  1  system clock (pixel clock domain of the DPU)
- `rst`  in  1  synchronous, active-high reset
- `Hcnt`  in  11  horizontal counter from the DPU timing chain
- `Vcnt`  in  11  vertical counter from the DPU timing chain
- `req`  in  1  update request from game logic (level, four-phase)
- `gameState_in`  in  3  proposed game state
- `p1State_in`, `p2State_in`  in  2 each  proposed player states
- `p1health_in`, `p2health_in`  in  4 each  proposed health
- `x1_in`, `x2_in`, `y1_in`, `y2_in`  in  11 each  proposed positions
- `p1Left_in`, `p2Left_in`  in  1 each  proposed facing
- `ack`  out  1  update committed; held until `req` falls
- `busy`  out  1  request accepted, waiting for vblank (PENDING)
- `gameState`, `p1State`, `p2State`, `p1health`, `p2health`, `x1`, `x2`, `y1`, `y2`, `p1Left`, `p2Left`  out  same widths as inputs  committed shadow state to the DPU
- `vblank`  out  1  registered `Vcnt >= V_ACTIVE`
- `frame_start`  out  1  one-cycle pulse, registered from `Hcnt == 0 && Vcnt == 0`
- `frame_cnt`  out  8  frames since reset, increments on `frame_start`

## Operation

- `vbs` (internal) = `Hcnt == 0 && Vcnt == V_ACTIVE`, combinational from inputs.
- FSM states: IDLE, PENDING, ACK.
  - IDLE: `req == 1` -> PENDING. This holds even if `vbs` is true in the same cycle; that occurrence is not used.
  - PENDING: `vbs == 1` -> ACK. On that same edge, all shadow registers load from the `_in` ports. `req` dropping while in PENDING is a protocol violation. The block still commits at the next `vbs` and then takes ACK -> IDLE immediately if `req == 0`.
  - ACK: `ack = 1`. `req == 0` -> IDLE. Stays in ACK while `req == 1`. No new commit occurs until a fresh rising request from IDLE.
- `busy = (state == PENDING)`. `ack = (state == ACK)`. Both are decoded from registered state.
- Clamping at commit:
  - `x1`, `x2` = min(in, `X_MAX`).
  - `y1`, `y2` = min(in, `Y_MAX`).
  - Health: values > 9 commit as 9.
  - All other fields are copied unchanged.
- Shadow registers change only on the commit edge and on reset.
- `frame_cnt` wraps 255 -> 0.
- `vblank` and `frame_start` run independently of the FSM.
- Game logic must hold the `_in` ports stable from `req` rise until `ack` is seen.

## Timing

- Reset (sync, `rst == 1` at edge): state = IDLE. `ack = 0`, `busy = 0`, `vblank = 0`, `frame_start = 0`, `frame_cnt = 0`. All shadow outputs = 0.
- Reset mid-operation (PENDING or ACK) aborts the request with no commit. Game logic must re-raise `req`.
- `req` sampled high at edge N (IDLE): `busy = 1` from N+1.
- First `vbs` cycle at edge M > N: shadows are valid and `ack = 1` from M+1, `busy = 0` from M+1.
- Worst-case latency is one full frame plus one cycle.
- `req` sampled low at edge K in ACK: `ack = 0` from K+1.
- `frame_start` is high exactly the cycle after `Hcnt == 0 && Vcnt == 0` is presented. `frame_cnt` increments on that same edge.
- `vblank` lags `Vcnt` by one cycle.

## Test plan

- Reset, then run the counters with no `req` -> all outputs 0 except the strobes. `frame_cnt` = 3 after three `frame_start` pulses. Shadows stay 0.
- `req` at Vcnt=100 with `x1_in=200`, `y1_in=300`, `gameState_in=2` -> `busy` next cycle. `ack` rises and shadows show 200/300/2 one cycle after Hcnt=0, Vcnt=600. Outputs are unchanged before that point.
- `req` rises on the exact cycle Hcnt=0, Vcnt=600 -> no commit this frame. Commit occurs at the next frame's Vcnt=600.
- Commit with `x2_in=900`, `y2_in=700`, `p1health_in=12` -> `x2=760`, `y2=500`, `p1health=9`.
- Hold `req` high across two vblanks after `ack` -> a single commit only. Changing `_in` during ACK does not alter the shadows. Drop `req` -> `ack` falls next cycle.
- Assert `rst` while in PENDING -> next cycle IDLE, `busy=0`, shadows 0. The following vblank makes no commit.
- 256 frames -> `frame_cnt` wraps to 0.
